// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Load-use stall, branch flush, memory freeze, perf counters and timeout.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_wr_reg_n,
   input  logic             id_is_load,
   input  logic             ex_br_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_bubble,
   output logic             ex_mem_we,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN,
      LD_STALL,
      MEM_WAIT
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic             ex_wr_q, ex_wr_d;
   logic             ex_load_q, ex_load_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic memw, lu, rs_hit;
   logic do_br, do_lu, do_run;

   always_comb begin
      memw   = mem_req & ~mem_ack;
      rs_hit = (id_use_rs1 & (id_rs1 == ex_rd_q))
             | (id_use_rs2 & (id_rs2 == ex_rd_q));
      lu     = ex_load_q & ex_wr_q & (ex_rd_q != 5'd0) & rs_hit;
      do_br  = ~memw & ex_br_taken;
      do_lu  = ~memw & ~ex_br_taken & lu;
      do_run = ~memw & ~ex_br_taken & ~lu;
   end

   always_comb begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_we     = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_we    = 1'b0;
      state_d      = state_q;
      ex_rd_d      = ex_rd_q;
      ex_wr_d      = ex_wr_q;
      ex_load_d    = ex_load_q;
      wait_cnt_d   = 16'd0;
      timeout_d    = timeout_q;
      flush_cnt_d  = flush_cnt_q;

      unique case (1'b1)
         memw: begin
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT)
               wait_cnt_d = 16'd1;
            else if (wait_cnt_q == 16'hFFFF)
               wait_cnt_d = wait_cnt_q;
            else
               wait_cnt_d = wait_cnt_q + 16'd1;
            if (32'(wait_cnt_d) >= MEM_TIMEOUT)
               timeout_d = 1'b1;
         end
         do_br: begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            ex_rd_d      = 5'd0;
            ex_wr_d      = 1'b0;
            ex_load_d    = 1'b0;
            state_d      = RUN;
            flush_cnt_d  = flush_cnt_q + CNT_ONE;
         end
         do_lu: begin
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            ex_rd_d      = 5'd0;
            ex_wr_d      = 1'b0;
            ex_load_d    = 1'b0;
            state_d      = LD_STALL;
         end
         do_run: begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            ex_rd_d   = id_rd;
            ex_wr_d   = ~id_wr_reg_n;
            ex_load_d = id_is_load;
            state_d   = RUN;
         end
         default: ;
      endcase

      // Reset forces a bubble into ID/EX and freezes everything else.
      if (!rst_n) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_we     = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_we    = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_we)
         stall_cnt_d = stall_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         ex_rd_q     <= 5'd0;
         ex_wr_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         wait_cnt_q  <= 16'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_rd_q     <= ex_rd_d;
         ex_wr_q     <= ex_wr_d;
         ex_load_q   <= ex_load_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected
// responses, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2, id_wr_reg_n, id_is_load;
   logic        ex_br_taken, mem_req, mem_ack;
   logic        pc_we, if_id_we, if_id_flush, id_ex_we;
   logic        id_ex_bubble, ex_mem_we, mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_wr_reg_n (id_wr_reg_n),
      .id_is_load  (id_is_load),
      .ex_br_taken (ex_br_taken),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .pc_we       (pc_we),
      .if_id_we    (if_id_we),
      .if_id_flush (if_id_flush),
      .id_ex_we    (id_ex_we),
      .id_ex_bubble(id_ex_bubble),
      .ex_mem_we   (ex_mem_we),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we}
   localparam logic [5:0] RST = 6'b001110;
   localparam logic [5:0] NRM = 6'b110101;
   localparam logic [5:0] BRF = 6'b111111;
   localparam logic [5:0] LDU = 6'b000111;
   localparam logic [5:0] FRZ = 6'b000000;

   typedef struct {
      int          id;
      logic [5:0]  c;
      logic        to;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec    = 0;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = q.pop_front();
         act = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we};
         checks += 4;
         if (act !== e.c) begin
            errors++;
            $display("FAIL ctrl v%0d got %b want %b", e.id, act, e.c);
         end
         if (mem_timeout !== e.to) begin
            errors++;
            $display("FAIL timeout v%0d got %b want %b", e.id, mem_timeout, e.to);
         end
         if (stall_cnt !== e.sc) begin
            errors++;
            $display("FAIL stall_cnt v%0d got %0d want %0d", e.id, stall_cnt, e.sc);
         end
         if (flush_cnt !== e.fc) begin
            errors++;
            $display("FAIL flush_cnt v%0d got %0d want %0d", e.id, flush_cnt, e.fc);
         end
      end
   end

   task automatic step(
      input logic       r,
      input logic [4:0] rs1, rs2,
      input logic       u1, u2,
      input logic [4:0] rd,
      input logic       wrn, ld, br, req, ack,
      input logic [5:0] c,
      input logic       to,
      input int         sc, fc
   );
      exp_t e;
      @(posedge clk);
      #1;
      rst_n       = r;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd       = rd;
      id_wr_reg_n = wrn;
      id_is_load  = ld;
      ex_br_taken = br;
      mem_req     = req;
      mem_ack     = ack;
      e.id = vec;
      e.c  = c;
      e.to = to;
      e.sc = sc;
      e.fc = fc;
      q.push_back(e);
      vec++;
   endtask

   initial begin
      rst_n = 1'b0;
      {id_rs1, id_rs2, id_rd} = '0;
      {id_use_rs1, id_use_rs2, id_wr_reg_n, id_is_load} = '0;
      {ex_br_taken, mem_req, mem_ack} = '0;

      //   r  rs1 rs2 u1 u2 rd wn ld br rq ak  ctrl to sc  fc
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, RST, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, RST, 0, 0, 0);
      // ADD x5 then SUB x6,x5,x1
      step(1, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
      // LW x5 then ADD x6,x5,x1: one stall
      step(1, 2, 0, 1, 0, 5, 0, 1, 0, 0, 0, NRM, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, LDU, 0, 0, 0);
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, NRM, 0, 1, 0);
      // LW x0 then use of x0
      step(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, NRM, 0, 1, 0);
      step(1, 0, 3, 1, 1, 7, 0, 0, 0, 0, 0, NRM, 0, 1, 0);
      // LW x5 then rs1=5 with use disabled
      step(1, 2, 0, 1, 0, 5, 0, 1, 0, 0, 0, NRM, 0, 1, 0);
      step(1, 5, 5, 0, 0, 8, 0, 0, 0, 0, 0, NRM, 0, 1, 0);
      // LW x9, then branch while load-use is live
      step(1, 2, 0, 1, 0, 9, 0, 1, 0, 0, 0, NRM, 0, 1, 0);
      step(1, 9, 1, 1, 1, 10, 0, 0, 1, 0, 0, BRF, 0, 1, 0);
      step(1, 9, 1, 1, 1, 10, 0, 0, 0, 0, 0, NRM, 0, 1, 1);
      // 3-cycle memory wait with pending branch
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, FRZ, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, FRZ, 0, 2, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, FRZ, 0, 3, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, BRF, 0, 4, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 0, 4, 2);
      // 6-cycle wait, timeout at 4
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 0, 4, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 0, 5, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 0, 6, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 0, 7, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 1, 8, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 1, 9, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, NRM, 1, 10, 2);
      // LW x5 into EX, then reset mid-wait
      step(1, 2, 0, 1, 0, 5, 0, 1, 0, 0, 0, NRM, 1, 10, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 1, 10, 2);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, FRZ, 1, 11, 2);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, RST, 0, 0, 0);
      // after release: scoreboard empty, x5 use does not stall
      step(1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, NRM, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 0, 0, 0);

      for (int i = 0; i < 4 && q.size() > 0; i++)
         @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
